// File: rtl/mu0_bus_monitor.sv
// mu0_bus_monitor: MU0 store tracer with run/store counters, completion and watchdog flags (watchdog under MU0_MON_WATCHDOG_EN)
module mu0_bus_monitor #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 1000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [11:0] Addr,
  input  logic [15:0] Dout,
  input  logic        Wr,
  input  logic        Halted,
  input  logic        Clear,
  input  logic        Pop,
  output logic        Trace_valid,
  output logic [11:0] Trace_addr,
  output logic [15:0] Trace_data,
  output logic        Overflow,
  output logic [15:0] Cycle_count,
  output logic [15:0] Write_count,
  output logic        Done,
  output logic        Timeout
);
  localparam int AW = $clog2(DEPTH);
`ifdef MU0_MON_WATCHDOG_EN
  typedef enum logic [1:0] {S_RUN, S_HALT, S_TMO} state_t;
`else
  typedef enum logic [1:0] {S_RUN, S_HALT} state_t;
`endif
  state_t st;
  logic [27:0] mem [DEPTH];
  logic [AW-1:0] rp, wp;
  logic [AW:0] cnt;
  logic run, empty, full, push, pop_ok, push_ok, hit;
  logic [15:0] cyc_inc, wc_inc;
  assign run = st == S_RUN;
  assign empty = cnt == '0;
  assign full = cnt == (AW+1)'(DEPTH);
  assign push = run & Wr;
  assign pop_ok = Pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign cyc_inc = &Cycle_count ? Cycle_count : Cycle_count + 16'd1;
  assign wc_inc = &Write_count ? Write_count : Write_count + 16'd1;
`ifdef MU0_MON_WATCHDOG_EN
  assign hit = cyc_inc == 16'(TIMEOUT);
  assign Timeout = st == S_TMO;
`else
  assign hit = 1'b0;
  assign Timeout = 1'b0;
`endif
  assign Done = st == S_HALT;
  assign Trace_valid = ~empty;
  assign Trace_addr = empty ? 12'd0 : mem[rp][27:16];
  assign Trace_data = empty ? 16'd0 : mem[rp][15:0];
  always_ff @(posedge Clk)
    if (push_ok && !Clear) mem[wp] <= {Addr, Dout};
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset || Clear) begin
      st <= S_RUN;
      rp <= '0;
      wp <= '0;
      cnt <= '0;
      Overflow <= 1'b0;
      Cycle_count <= 16'd0;
      Write_count <= 16'd0;
    end else begin
      if (pop_ok) rp <= rp + AW'(1);
      if (push_ok) wp <= wp + AW'(1);
      cnt <= cnt + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
      if (push & full & ~pop_ok) Overflow <= 1'b1;
      if (run) begin
        Cycle_count <= cyc_inc;
        if (Wr) Write_count <= wc_inc;
`ifdef MU0_MON_WATCHDOG_EN
        st <= Halted ? S_HALT : hit ? S_TMO : S_RUN;
`else
        st <= Halted ? S_HALT : S_RUN;
`endif
      end
    end
endmodule

// File: tb/tb_mu0_bus_monitor.sv
// tb_mu0_bus_monitor: scoreboard bench for mu0_bus_monitor against a queue-based reference model
module tb_mu0_bus_monitor;
  localparam int DEPTH = 8;
  localparam int TO = 50;
`ifdef MU0_MON_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif
  logic Clk = 1'b0, Reset = 1'b0, Wr = 1'b0, Halted = 1'b0, Clear = 1'b0, Pop = 1'b0;
  logic [11:0] Addr = 12'd0;
  logic [15:0] Dout = 16'd0;
  logic Trace_valid, Overflow, Done, Timeout;
  logic [11:0] Trace_addr;
  logic [15:0] Trace_data, Cycle_count, Write_count;
  always #5 Clk = ~Clk;
  mu0_bus_monitor #(.DEPTH(DEPTH), .TIMEOUT(TO)) dut (
    .Clk(Clk), .Reset(Reset), .Addr(Addr), .Dout(Dout), .Wr(Wr), .Halted(Halted),
    .Clear(Clear), .Pop(Pop), .Trace_valid(Trace_valid), .Trace_addr(Trace_addr),
    .Trace_data(Trace_data), .Overflow(Overflow), .Cycle_count(Cycle_count),
    .Write_count(Write_count), .Done(Done), .Timeout(Timeout)
  );
  typedef struct packed {
    logic v; logic [11:0] a; logic [15:0] d; logic o;
    logic [15:0] c; logic [15:0] w; logic dn; logic tm;
  } snap_t;
  snap_t expq[$];
  logic [27:0] mq[$];
  int m_cyc, m_wc, m_st;
  bit m_ovf;
  int total = 0, bad = 0;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask
  task automatic model_reset();
    m_cyc = 0; m_wc = 0; m_st = 0; m_ovf = 0; mq.delete();
  endtask
  function automatic snap_t cur();
    snap_t s;
    s.v = mq.size() > 0;
    s.a = s.v ? mq[0][27:16] : 12'd0;
    s.d = s.v ? mq[0][15:0] : 16'd0;
    s.o = m_ovf;
    s.c = 16'(m_cyc);
    s.w = 16'(m_wc);
    s.dn = m_st == 1;
    s.tm = m_st == 2;
    return s;
  endfunction
  task automatic drive(input logic w, input logic [11:0] a, input logic [15:0] d,
                       input logic h, input logic c, input logic p);
    bit po, fu;
    Wr = w; Addr = a; Dout = d; Halted = h; Clear = c; Pop = p;
    if (c) model_reset();
    else begin
      po = p && mq.size() > 0;
      fu = mq.size() == DEPTH;
      if (po) void'(mq.pop_front());
      if (m_st == 0 && w) begin
        if (fu && !po) m_ovf = 1;
        else mq.push_back({a, d});
      end
      if (m_st == 0) begin
        if (m_cyc < 65535) m_cyc++;
        if (w && m_wc < 65535) m_wc++;
        if (h) m_st = 1;
        else if (WD && m_cyc == TO) m_st = 2;
      end
    end
    expq.push_back(cur());
  endtask
  task automatic step(input logic w, input logic [11:0] a, input logic [15:0] d,
                      input logic h, input logic c, input logic p);
    @(negedge Clk);
    drive(w, a, d, h, c, p);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, ".valid"}, 32'(Trace_valid), 0);
    chk({tag, ".addr"}, 32'(Trace_addr), 0);
    chk({tag, ".data"}, 32'(Trace_data), 0);
    chk({tag, ".ovf"}, 32'(Overflow), 0);
    chk({tag, ".cyc"}, 32'(Cycle_count), 0);
    chk({tag, ".wc"}, 32'(Write_count), 0);
    chk({tag, ".done"}, 32'(Done), 0);
    chk({tag, ".tmo"}, 32'(Timeout), 0);
  endtask
  snap_t e;
  initial forever begin
    @(posedge Clk);
    #1;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      chk("valid", 32'(Trace_valid), 32'(e.v));
      chk("addr", 32'(Trace_addr), 32'(e.a));
      chk("data", 32'(Trace_data), 32'(e.d));
      chk("ovf", 32'(Overflow), 32'(e.o));
      chk("cyc", 32'(Cycle_count), 32'(e.c));
      chk("wc", 32'(Write_count), 32'(e.w));
      chk("done", 32'(Done), 32'(e.dn));
      chk("tmo", 32'(Timeout), 32'(e.tm));
    end
  end
  initial begin
    model_reset();
    repeat (2) @(posedge Clk);
    #1 chk_zero("rst");
    @(negedge Clk);
    Reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    repeat (4) step(0, 0, 0, 0, 0, 0);
    step(1, 12'h010, 16'h1234, 0, 0, 0);
    step(1, 12'h011, 16'hABCD, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 9; i++) step(1, 12'(i + 32), 16'($urandom), 0, 0, 0);
    step(1, 12'h0FF, 16'hBEEF, 0, 0, 1);
    for (int i = 0; i < 9; i++) step(0, 0, 0, 0, 0, 1);
    step(1, 12'h123, 16'h5555, 0, 0, 1);
    step(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 19; i++) step(i < 3, 12'(i + 64), 16'($urandom), 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    repeat (3) step(1, 12'h777, 16'h7777, 0, 0, 0);
    repeat (4) step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 0);
    repeat (60) step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++)
      step(1'($urandom), 12'($urandom), 16'($urandom), $urandom_range(0, 63) == 0,
           $urandom_range(0, 39) == 0, $urandom_range(0, 2) == 0);
    step(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 12'(i + 200), 16'($urandom), 0, 0, 0);
    @(negedge Clk);
    #2 Reset = 1'b0;
    #1 chk_zero("midrst");
    model_reset();
    @(negedge Clk);
    Reset = 1'b1;
    drive(1, 12'h3AA, 16'h0F0F, 0, 0, 0);
    repeat (5) step(1'($urandom), 12'($urandom), 16'($urandom), 0, 0, 1'($urandom));
    repeat (3) @(posedge Clk);
    #2 chk("drain", 32'(expq.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
